// File: rtl/rc4_key_search_ctrl_if.sv
// ----------------------------------------------------------------------------
// rc4_key_search_ctrl_if
//   Link between the key-search controller and the RC4 KSA/decrypt pipeline.
//
//   Signals:
//     dec_reset  controller -> decryptor  one-cycle pipeline reset pulse
//     dec_start  controller -> decryptor  one-cycle pipeline start pulse
//     dec_done   decryptor -> controller  done level, held until dec_reset
//     dec_msg    decryptor -> controller  decrypted bytes, stable while done
//
//   Modports:
//     master  the key-search controller
//     slave   the decryptor (or a behavioural model of it)
// ----------------------------------------------------------------------------
interface rc4_key_search_ctrl_if #(
  parameter int MSG_DEP   = 32,
  parameter int MSG_WIDTH = 8
);

  logic                 dec_reset;
  logic                 dec_start;
  logic                 dec_done;
  logic [MSG_WIDTH-1:0] dec_msg [MSG_DEP];

  modport master (
    output dec_reset,
    output dec_start,
    input  dec_done,
    input  dec_msg
  );

  modport slave (
    input  dec_reset,
    input  dec_start,
    output dec_done,
    output dec_msg
  );

endinterface

// File: rtl/rc4_key_search_ctrl.sv
// ----------------------------------------------------------------------------
// rc4_key_search_ctrl
//   Brute-force key search loop around the RC4 decryptor. Walks a candidate
//   key from KEY_START to KEY_END; for each key it resets and launches the
//   decrypt pipeline, waits for done, then scans the message one byte per
//   cycle for plaintext (a-z or space). Stops on the first passing key or
//   reports that the range is exhausted.
//
//   Ports:
//     clk              clock
//     reset            synchronous, active-high reset
//     i_start_search   level, sampled in IDLE to begin a search
//     dec_if           master side of the decryptor link (reset/start/done/msg)
//     o_secret_key     current candidate key, final value once found
//     o_busy           high while searching (not IDLE/FOUND/EXHAUSTED)
//     o_key_found      sticky, valid key is on o_secret_key
//     o_key_not_found  sticky, range exhausted without a match
//     o_attempts       number of keys scanned (only with the macro below)
//
//   Optional feature:
//     KEY_SEARCH_ATTEMPT_CNT_EN  adds the o_attempts counter output.
// ----------------------------------------------------------------------------
module rc4_key_search_ctrl #(
  parameter int                   MSG_DEP   = 32,
  parameter int                   MSG_WIDTH = 8,
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END   = 24'h3FFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start_search,
  rc4_key_search_ctrl_if.master    dec_if,
  output logic [KEY_WIDTH-1:0]     o_secret_key,
  output logic                     o_busy,
  output logic                     o_key_found,
  output logic                     o_key_not_found
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
  ,
  output logic [KEY_WIDTH:0]       o_attempts
`endif
);

  localparam int IDX_W = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_DEP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_PIPE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_SCAN,
    S_NEXT_KEY,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_dec_reset;
  logic                 r_dec_start;
  logic                 r_busy;
  logic                 r_found;
  logic                 r_not_found;
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
  logic [KEY_WIDTH:0]   r_attempts;
`endif

  logic [MSG_WIDTH-1:0] w_byte;
  logic                 w_byte_ok;

  // Plaintext test on the byte currently addressed by the scan index.
  assign w_byte    = dec_if.dec_msg[r_idx];
  assign w_byte_ok = ((w_byte >= MSG_WIDTH'(8'h61)) && (w_byte <= MSG_WIDTH'(8'h7A))) ||
                     (w_byte == MSG_WIDTH'(8'h20));

  // Pulse outputs are set on the transition into their state so that the
  // registered pulse is high for exactly the cycle spent in that state.
  // o_busy is likewise computed from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_key       <= KEY_START;
      r_dec_reset <= 1'b0;
      r_dec_start <= 1'b0;
      r_busy      <= 1'b0;
      r_found     <= 1'b0;
      r_not_found <= 1'b0;
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
      r_attempts  <= '0;
`endif
    end else begin
      r_dec_reset <= 1'b0;
      r_dec_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_search) begin
            r_key       <= KEY_START;
            r_dec_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_RESET_PIPE;
          end
        end
        S_RESET_PIPE: begin
          r_dec_start <= 1'b1;
          r_state     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_idx   <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Done cannot be stale here: dec_reset cleared it before launch.
          if (dec_if.dec_done) begin
            r_state <= S_SCAN;
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
            r_attempts <= r_attempts + (KEY_WIDTH + 1)'(1);
`endif
          end
        end
        S_SCAN: begin
          if (!w_byte_ok) begin
            r_state <= S_NEXT_KEY;
          end else if (r_idx == LAST_IDX) begin
            r_found <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FOUND;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_NEXT_KEY: begin
          // KEY_END bounds the increment, so the key never wraps.
          if (r_key == KEY_END) begin
            r_not_found <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_EXHAUSTED;
          end else begin
            r_key       <= r_key + KEY_WIDTH'(1);
            r_dec_reset <= 1'b1;
            r_state     <= S_RESET_PIPE;
          end
        end
        S_FOUND, S_EXHAUSTED: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dec_if.dec_reset = r_dec_reset;
  assign dec_if.dec_start = r_dec_start;
  assign o_secret_key     = r_key;
  assign o_busy           = r_busy;
  assign o_key_found      = r_found;
  assign o_key_not_found  = r_not_found;
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
  assign o_attempts       = r_attempts;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
//   Directed bench for rc4_key_search_ctrl. Instance A searches keys 0..8
//   against a behavioural decryptor whose message content depends on a
//   selectable mode and on the current key. Instance B has a single-key range
//   (7..7) and a decryptor that answers done immediately after start.
//   Honours KEY_SEARCH_ATTEMPT_CNT_EN when defined.
// ----------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startSearch = 1'b0;
  logic startSearchB = 1'b0;

  always #5 clk = ~clk;

  // Instance A: keys 0..8, 32-byte messages
  rc4_key_search_ctrl_if #(.MSG_DEP(32), .MSG_WIDTH(8)) decBus ();
  logic [23:0] secretKey;
  logic        busy, keyFound, keyNotFound;
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
  logic [24:0] attempts;
`endif

  rc4_key_search_ctrl #(
    .MSG_DEP(32), .MSG_WIDTH(8), .KEY_WIDTH(24),
    .KEY_START(24'd0), .KEY_END(24'd8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start_search  (startSearch),
    .dec_if          (decBus.master),
    .o_secret_key    (secretKey),
    .o_busy          (busy),
    .o_key_found     (keyFound),
    .o_key_not_found (keyNotFound)
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    ,
    .o_attempts      (attempts)
`endif
  );

  // Instance B: single key 7, 4-byte messages
  rc4_key_search_ctrl_if #(.MSG_DEP(4), .MSG_WIDTH(8)) decBusB ();
  logic [23:0] secretKeyB;
  logic        busyB, keyFoundB, keyNotFoundB;
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
  logic [24:0] attemptsB;
`endif

  rc4_key_search_ctrl #(
    .MSG_DEP(4), .MSG_WIDTH(8), .KEY_WIDTH(24),
    .KEY_START(24'd7), .KEY_END(24'd7)
  ) dutB (
    .clk             (clk),
    .reset           (reset),
    .i_start_search  (startSearchB),
    .dec_if          (decBusB.master),
    .o_secret_key    (secretKeyB),
    .o_busy          (busyB),
    .o_key_found     (keyFoundB),
    .o_key_not_found (keyNotFoundB)
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    ,
    .o_attempts      (attemptsB)
`endif
  );

  int msgMode = 0;
  int decLatency = 4;
  int checkCount = 0;
  int errorCount = 0;

  // Message content: mode 0 passes only key 5, mode 1 fails at byte 0,
  // mode 2 fails at the last byte (0x60), mode 3 fails key 0 at the last
  // byte (0x7B) and passes other keys with a 0x20/0x61/0x7A pattern.
  function automatic logic [7:0] msgByte(input int mode, input logic [23:0] key, input int idx);
    logic [7:0] b;
    b = 8'h61;
    case (mode)
      0: begin
        if (key == 24'd5) b = (idx % 6 == 5) ? 8'h20 : 8'h61 + 8'(idx % 26);
        else              b = (idx == 0) ? 8'h00 : 8'h61;
      end
      1: b = (idx == 0) ? 8'h00 : 8'h61;
      2: b = (idx == 31) ? 8'h60 : 8'h61;
      default: begin
        if (key == 24'd0) b = (idx == 31) ? 8'h7B : 8'h7A;
        else if (idx % 3 == 0) b = 8'h20;
        else if (idx % 3 == 1) b = 8'h61;
        else b = 8'h7A;
      end
    endcase
    return b;
  endfunction

  // Behavioural decryptor A: done rises decLatency cycles after start and
  // is held until the next dec_reset.
  logic running = 1'b0;
  int   latCnt = 0;
  always @(posedge clk) begin
    if (reset || decBus.dec_reset) begin
      decBus.dec_done <= 1'b0;
      running <= 1'b0;
    end else if (decBus.dec_start) begin
      running <= 1'b1;
      latCnt <= decLatency;
    end else if (running) begin
      if (latCnt <= 1) begin
        running <= 1'b0;
        decBus.dec_done <= 1'b1;
        for (int i = 0; i < 32; i++) decBus.dec_msg[i] <= msgByte(msgMode, secretKey, i);
      end else begin
        latCnt <= latCnt - 1;
      end
    end
  end

  // Behavioural decryptor B: done already high when WAIT_DONE is entered;
  // message fails on its last byte.
  always @(posedge clk) begin
    if (reset || decBusB.dec_reset) begin
      decBusB.dec_done <= 1'b0;
    end else if (decBusB.dec_start) begin
      decBusB.dec_done <= 1'b1;
      for (int i = 0; i < 4; i++) decBusB.dec_msg[i] <= (i == 3) ? 8'h7B : 8'h20;
    end
  end

  // Pulse counters and the distance from a done rise to the next dec_reset.
  int   cyc = 0;
  int   resetPulses = 0, startPulses = 0, resetPulsesB = 0, startPulsesB = 0;
  int   doneRiseCyc = 0, lastGap = 0;
  logic prevDone = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (decBus.dec_reset)  resetPulses  <= resetPulses + 1;
    if (decBus.dec_start)  startPulses  <= startPulses + 1;
    if (decBusB.dec_reset) resetPulsesB <= resetPulsesB + 1;
    if (decBusB.dec_start) startPulsesB <= startPulsesB + 1;
    if (decBus.dec_done && !prevDone) doneRiseCyc <= cyc;
    if (decBus.dec_reset) lastGap <= cyc - doneRiseCyc;
    prevDone <= decBus.dec_done;
  end

  int resets0, starts0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input int latency);
    msgMode = mode;
    decLatency = latency;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    resets0 = resetPulses;
    starts0 = startPulses;
    startSearch = 1'b1;
    @(negedge clk);
    startSearch = 1'b0;
  endtask

  task automatic waitTerminal(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!(keyFound || keyNotFound) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(keyFound | keyNotFound), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, unstable, rs, ss;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_key", 32'(secretKey), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_found", 32'(keyFound), 32'd0);
    checkOutput("rst_notfound", 32'(keyNotFound), 32'd0);
    checkOutput("rst_decreset", 32'(decBus.dec_reset), 32'd0);
    checkOutput("rst_decstart", 32'(decBus.dec_start), 32'd0);
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    checkOutput("rst_attempts", 32'(attempts), 32'd0);
`endif

    // Only key 5 passes; keys 0..4 exit at byte 0
    applyStimulus(0, 4);
    @(negedge clk);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitTerminal("t1_term", 2000);
    checkOutput("t1_found", 32'(keyFound), 32'd1);
    checkOutput("t1_notfound", 32'(keyNotFound), 32'd0);
    checkOutput("t1_key", 32'(secretKey), 32'd5);
    checkOutput("t1_starts", 32'(startPulses - starts0), 32'd6);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t4_early_gap", 32'(lastGap), 32'd3);
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    checkOutput("t1_attempts", 32'(attempts), 32'd6);
`endif

    // start_search held high in FOUND must be ignored
    rs = resetPulses;
    ss = startPulses;
    unstable = 0;
    startSearch = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (secretKey !== 24'd5 || keyFound !== 1'b1) unstable++;
    end
    startSearch = 1'b0;
    checkOutput("t6_stable", 32'(unstable), 32'd0);
    checkOutput("t6_resets", 32'(resetPulses - rs), 32'd0);
    checkOutput("t6_starts", 32'(startPulses - ss), 32'd0);

    // Every key fails at byte 0 -> exhausted at KEY_END
    applyStimulus(1, 4);
    waitTerminal("t2_term", 2000);
    checkOutput("t2_notfound", 32'(keyNotFound), 32'd1);
    checkOutput("t2_found", 32'(keyFound), 32'd0);
    checkOutput("t2_key", 32'(secretKey), 32'd8);
    checkOutput("t2_resets", 32'(resetPulses - resets0), 32'd9);
    checkOutput("t2_starts", 32'(startPulses - starts0), 32'd9);
    checkOutput("t2_busy", 32'(busy), 32'd0);
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    checkOutput("t2_attempts", 32'(attempts), 32'd9);
`endif

    // Last byte 0x60 fails after a full 32-byte scan
    applyStimulus(2, 4);
    waitTerminal("t3a_term", 3000);
    checkOutput("t3a_notfound", 32'(keyNotFound), 32'd1);
    checkOutput("t3a_gap", 32'(lastGap), 32'd34);

    // Key 0 last byte 0x7B fails; key 1 boundary bytes pass
    applyStimulus(3, 4);
    waitTerminal("t3b_term", 2000);
    checkOutput("t3b_found", 32'(keyFound), 32'd1);
    checkOutput("t3b_key", 32'(secretKey), 32'd1);
    checkOutput("t3b_gap", 32'(lastGap), 32'd34);
    checkOutput("t3b_starts", 32'(startPulses - starts0), 32'd2);
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    checkOutput("t3b_attempts", 32'(attempts), 32'd2);
`endif

    // Reset during WAIT_DONE at key 3
    applyStimulus(1, 20);
    n = 0;
    while (!(decBus.dec_start && secretKey == 24'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_reach_key3", 32'(decBus.dec_start && secretKey == 24'd3), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t5_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t5_key", 32'(secretKey), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_flags", 32'({keyFound, keyNotFound}), 32'd0);
    checkOutput("t5_pulses", 32'({decBus.dec_reset, decBus.dec_start}), 32'd0);
    ss = startPulses;
    repeat (30) @(negedge clk);
    checkOutput("t5_no_start", 32'(startPulses - ss), 32'd0);
    startSearch = 1'b1;
    @(negedge clk);
    startSearch = 1'b0;
    waitTerminal("t5_term", 3000);
    checkOutput("t5_restart_key", 32'(secretKey), 32'd8);
    checkOutput("t5_restart_starts", 32'(startPulses - ss), 32'd9);

    // Single-key range with done already high on WAIT_DONE entry
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rs = resetPulsesB;
    ss = startPulsesB;
    startSearchB = 1'b1;
    @(negedge clk);
    startSearchB = 1'b0;
    n = 0;
    while (!(keyFoundB || keyNotFoundB) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tB_term", 32'(keyFoundB | keyNotFoundB), 32'd1);
    checkOutput("tB_notfound", 32'(keyNotFoundB), 32'd1);
    checkOutput("tB_found", 32'(keyFoundB), 32'd0);
    checkOutput("tB_key", 32'(secretKeyB), 32'd7);
    checkOutput("tB_starts", 32'(startPulsesB - ss), 32'd1);
    checkOutput("tB_resets", 32'(resetPulsesB - rs), 32'd1);
    checkOutput("tB_busy", 32'(busyB), 32'd0);
`ifdef KEY_SEARCH_ATTEMPT_CNT_EN
    checkOutput("tB_attempts", 32'(attemptsB), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
